// File: rtl/bcd_7448_decoder_if.sv
// ---------------------------------------------------------------------------
// bcd_7448_decoder_if
//   Connection bundle between a BCD source and one 7448-style display digit.
//   Signals:
//     bcd  4  BCD digit; codes 10-15 are decoded to 7448 glyphs
//     lt   1  lamp test, active-low (all segments on)
//     bi   1  blanking input, active-low (all segments off)
//     rbi  1  ripple-blank input, active-low (blank a zero digit)
//     seg  7  segment drive, active-high, seg[0]=a .. seg[6]=g
//     rbo  1  ripple-blank output, active-low; feeds the next digit's rbi
//   Modports:
//     master  digit source / display side: drives inputs, observes outputs
//     slave   the decoder itself
// ---------------------------------------------------------------------------
interface bcd_7448_decoder_if;
  logic [3:0] bcd;
  logic       lt;
  logic       bi;
  logic       rbi;
  logic [6:0] seg;
  logic       rbo;

  modport master (
    output bcd,
    output lt,
    output bi,
    output rbi,
    input  seg,
    input  rbo
  );

  modport slave (
    input  bcd,
    input  lt,
    input  bi,
    input  rbi,
    output seg,
    output rbo
  );
endinterface

// File: rtl/bcd_7448_decoder.sv
// ---------------------------------------------------------------------------
// bcd_7448_decoder
//   BCD-to-7-segment decoder modelled on the 7448 (common-cathode,
//   active-high segment drive) with lamp test, blanking input and ripple
//   blanking for leading-zero suppression across cascaded digits.
//   The decode is purely combinational and feeds a single register stage,
//   so seg/rbo reflect the inputs sampled at the previous rising clk edge.
//   Ports:
//     clk  1  system clock, rising edge
//     rst  1  asynchronous, active-high reset: seg=0, rbo=1
//     dif     bcd_7448_decoder_if.slave (bcd, lt, bi, rbi in; seg, rbo out)
// ---------------------------------------------------------------------------
module bcd_7448_decoder (
  input  logic                    clk,
  input  logic                    rst,
  bcd_7448_decoder_if.slave       dif
);

  localparam logic [6:0] SEG_OFF = 7'h00;
  localparam logic [6:0] SEG_ALL = 7'h7F;

  // 7448 glyph table, bit order {g,f,e,d,c,b,a}. 6 and 9 have no tails;
  // code 15 is a blank glyph but is not a ripple-blank condition.
  function automatic logic [6:0] decode_glyph(input logic [3:0] digit);
    logic [6:0] glyph;
    case (digit)
      4'd0:    glyph = 7'h3F;
      4'd1:    glyph = 7'h06;
      4'd2:    glyph = 7'h5B;
      4'd3:    glyph = 7'h4F;
      4'd4:    glyph = 7'h66;
      4'd5:    glyph = 7'h6D;
      4'd6:    glyph = 7'h7C;
      4'd7:    glyph = 7'h07;
      4'd8:    glyph = 7'h7F;
      4'd9:    glyph = 7'h67;
      4'd10:   glyph = 7'h58;
      4'd11:   glyph = 7'h4C;
      4'd12:   glyph = 7'h62;
      4'd13:   glyph = 7'h69;
      4'd14:   glyph = 7'h78;
      4'd15:   glyph = 7'h00;
      default: glyph = 7'h00;
    endcase
    return glyph;
  endfunction

  logic [6:0] seg_nxt_s;
  logic       rbo_nxt_s;
  logic       zero_digit_s;
  logic [6:0] seg_r;
  logic       rbo_r;

  assign zero_digit_s = (dif.bcd == 4'd0);

  // Control priority: blanking beats lamp test beats ripple blanking beats decode.
  always_comb begin
    seg_nxt_s = SEG_OFF;
    rbo_nxt_s = 1'b1;
    if (dif.bi == 1'b0) begin
      // BI doubles as an input to the ripple chain, so rbo goes low too.
      seg_nxt_s = SEG_OFF;
      rbo_nxt_s = 1'b0;
    end else if (dif.lt == 1'b0) begin
      seg_nxt_s = SEG_ALL;
      rbo_nxt_s = 1'b1;
    end else if ((dif.rbi == 1'b0) && zero_digit_s) begin
      // Leading zero: suppress it and tell the next digit it may blank too.
      seg_nxt_s = SEG_OFF;
      rbo_nxt_s = 1'b0;
    end else begin
      seg_nxt_s = decode_glyph(dif.bcd);
      rbo_nxt_s = 1'b1;
    end
  end

  // Output register stage with asynchronous clear to the dark/idle state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_r <= SEG_OFF;
      rbo_r <= 1'b1;
    end else begin
      seg_r <= seg_nxt_s;
      rbo_r <= rbo_nxt_s;
    end
  end

  assign dif.seg = seg_r;
  assign dif.rbo = rbo_r;

endmodule

// File: tb/tb_bcd_7448_decoder.sv
// ---------------------------------------------------------------------------
// tb_bcd_7448_decoder
//   Self-checking bench for bcd_7448_decoder: reset behaviour, a directed
//   vector table, randomized vectors against a segment-letter reference
//   model, and a two-digit ripple-blanking cascade.
// ---------------------------------------------------------------------------
module tb_bcd_7448_decoder;

  logic clk;
  logic rst;

  bcd_7448_decoder_if if1 ();
  bcd_7448_decoder_if if2 ();

  // Digit 2 is cascaded behind digit 1.
  assign if2.rbi = if1.rbo;

  bcd_7448_decoder dut1 (.clk(clk), .rst(rst), .dif(if1));
  bcd_7448_decoder dut2 (.clk(clk), .rst(rst), .dif(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] bcd;
    logic       lt;
    logic       bi;
    logic       rbi;
    logic [6:0] seg;
    logic       rbo;
    string      name;
  } vec_t;

  vec_t vecs[$];

  // Lit segments per digit written as letters a..g.
  string glyph_letters[16];

  function automatic logic [6:0] letters_to_mask(input string s);
    logic [6:0] m;
    m = 7'h00;
    for (int i = 0; i < s.len(); i++) begin
      m[s[i] - 8'd97] = 1'b1;
    end
    return m;
  endfunction

  // Reference: returns {rbo, seg}.
  function automatic logic [7:0] model(input logic [3:0] b, input logic lt,
                                       input logic bi, input logic rbi);
    if (!bi) return {1'b0, 7'h00};
    if (!lt) return {1'b1, 7'h7F};
    if (!rbi && b == 4'd0) return {1'b0, 7'h00};
    return {1'b1, letters_to_mask(glyph_letters[b])};
  endfunction

  task automatic check(input string name, input logic [6:0] seg_act,
                       input logic rbo_act, input logic [6:0] seg_exp,
                       input logic rbo_exp);
    checks++;
    if (seg_act !== seg_exp || rbo_act !== rbo_exp) begin
      errors++;
      $display("FAIL %s: seg=%h rbo=%b, required seg=%h rbo=%b",
               name, seg_act, rbo_act, seg_exp, rbo_exp);
    end
  endtask

  task automatic apply1(input logic [3:0] b, input logic lt, input logic bi,
                        input logic rbi);
    @(negedge clk);
    if1.bcd = b; if1.lt = lt; if1.bi = bi; if1.rbi = rbi;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp;
    logic [3:0] rb;
    logic rlt, rbi_n, rrbi;

    glyph_letters[0]  = "abcdef";  glyph_letters[1]  = "bc";
    glyph_letters[2]  = "abdeg";   glyph_letters[3]  = "abcdg";
    glyph_letters[4]  = "bcfg";    glyph_letters[5]  = "acdfg";
    glyph_letters[6]  = "cdefg";   glyph_letters[7]  = "abc";
    glyph_letters[8]  = "abcdefg"; glyph_letters[9]  = "abcfg";
    glyph_letters[10] = "deg";     glyph_letters[11] = "cdg";
    glyph_letters[12] = "bfg";     glyph_letters[13] = "adfg";
    glyph_letters[14] = "defg";    glyph_letters[15] = "";

    // Directed table: plain sweep 0..15 then the control corner cases.
    vecs.push_back('{4'd0,  1'b1, 1'b1, 1'b1, 7'h3F, 1'b1, "d0"});
    vecs.push_back('{4'd1,  1'b1, 1'b1, 1'b1, 7'h06, 1'b1, "d1"});
    vecs.push_back('{4'd2,  1'b1, 1'b1, 1'b1, 7'h5B, 1'b1, "d2"});
    vecs.push_back('{4'd3,  1'b1, 1'b1, 1'b1, 7'h4F, 1'b1, "d3"});
    vecs.push_back('{4'd4,  1'b1, 1'b1, 1'b1, 7'h66, 1'b1, "d4"});
    vecs.push_back('{4'd5,  1'b1, 1'b1, 1'b1, 7'h6D, 1'b1, "d5"});
    vecs.push_back('{4'd6,  1'b1, 1'b1, 1'b1, 7'h7C, 1'b1, "d6"});
    vecs.push_back('{4'd7,  1'b1, 1'b1, 1'b1, 7'h07, 1'b1, "d7"});
    vecs.push_back('{4'd8,  1'b1, 1'b1, 1'b1, 7'h7F, 1'b1, "d8"});
    vecs.push_back('{4'd9,  1'b1, 1'b1, 1'b1, 7'h67, 1'b1, "d9"});
    vecs.push_back('{4'd10, 1'b1, 1'b1, 1'b1, 7'h58, 1'b1, "d10"});
    vecs.push_back('{4'd11, 1'b1, 1'b1, 1'b1, 7'h4C, 1'b1, "d11"});
    vecs.push_back('{4'd12, 1'b1, 1'b1, 1'b1, 7'h62, 1'b1, "d12"});
    vecs.push_back('{4'd13, 1'b1, 1'b1, 1'b1, 7'h69, 1'b1, "d13"});
    vecs.push_back('{4'd14, 1'b1, 1'b1, 1'b1, 7'h78, 1'b1, "d14"});
    vecs.push_back('{4'd15, 1'b1, 1'b1, 1'b1, 7'h00, 1'b1, "d15"});
    vecs.push_back('{4'd5,  1'b1, 1'b0, 1'b1, 7'h00, 1'b0, "bi_blank"});
    vecs.push_back('{4'd5,  1'b0, 1'b0, 1'b1, 7'h00, 1'b0, "bi_over_lt"});
    vecs.push_back('{4'd3,  1'b0, 1'b1, 1'b1, 7'h7F, 1'b1, "lamp_test"});
    vecs.push_back('{4'd0,  1'b0, 1'b1, 1'b0, 7'h7F, 1'b1, "lt_over_rbi"});
    vecs.push_back('{4'd0,  1'b1, 1'b1, 1'b0, 7'h00, 1'b0, "rbi_zero"});
    vecs.push_back('{4'd7,  1'b1, 1'b1, 1'b0, 7'h07, 1'b1, "rbi_nonzero"});
    vecs.push_back('{4'd15, 1'b1, 1'b1, 1'b0, 7'h00, 1'b1, "rbi_d15"});
    vecs.push_back('{4'd0,  1'b1, 1'b0, 1'b0, 7'h00, 1'b0, "bi_rbi_zero"});

    // Reset held from time zero: outputs clear with no clock edge.
    rst = 1'b1;
    if1.bcd = 4'd8; if1.lt = 1'b0; if1.bi = 1'b1; if1.rbi = 1'b1;
    if2.bcd = 4'd1; if2.lt = 1'b1; if2.bi = 1'b1;
    #2;
    check("reset_async", if1.seg, if1.rbo, 7'h00, 1'b1);
    @(posedge clk); #1;
    check("reset_held", if1.seg, if1.rbo, 7'h00, 1'b1);

    @(negedge clk);
    rst = 1'b0;
    if1.bcd = 4'd0; if1.lt = 1'b1; if1.bi = 1'b1; if1.rbi = 1'b1;
    @(posedge clk); #1;
    check("first_after_reset", if1.seg, if1.rbo, 7'h3F, 1'b1);

    // Latency: output must still hold the previous value before the edge.
    @(negedge clk);
    if1.bcd = 4'd4;
    #1;
    check("latency_hold", if1.seg, if1.rbo, 7'h3F, 1'b1);
    @(posedge clk); #1;
    check("latency_update", if1.seg, if1.rbo, 7'h66, 1'b1);

    foreach (vecs[i]) begin
      apply1(vecs[i].bcd, vecs[i].lt, vecs[i].bi, vecs[i].rbi);
      check(vecs[i].name, if1.seg, if1.rbo, vecs[i].seg, vecs[i].rbo);
    end

    // Randomized vectors against the reference model, controls biased high.
    for (int n = 0; n < 300; n++) begin
      rb    = 4'($urandom_range(0, 15));
      rlt   = ($urandom_range(0, 3) != 0);
      rbi_n = ($urandom_range(0, 3) != 0);
      rrbi  = ($urandom_range(0, 1) != 0);
      apply1(rb, rlt, rbi_n, rrbi);
      exp = model(rb, rlt, rbi_n, rrbi);
      check("random", if1.seg, if1.rbo, exp[6:0], exp[7]);
    end

    // Reset asserted between edges mid-operation.
    apply1(4'd8, 1'b1, 1'b1, 1'b1);
    check("pre_midreset", if1.seg, if1.rbo, 7'h7F, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("midreset_async", if1.seg, if1.rbo, 7'h00, 1'b1);
    @(posedge clk); #1;
    check("midreset_held", if1.seg, if1.rbo, 7'h00, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("release_no_edge", if1.seg, if1.rbo, 7'h00, 1'b1);
    @(posedge clk); #1;
    check("release_edge", if1.seg, if1.rbo, 7'h7F, 1'b1);

    // Cascade: digits 0,4 with the leading rbi low.
    @(negedge clk);
    if1.bcd = 4'd0; if1.lt = 1'b1; if1.bi = 1'b1; if1.rbi = 1'b0;
    if2.bcd = 4'd4; if2.lt = 1'b1; if2.bi = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("cascade04_d1", if1.seg, if1.rbo, 7'h00, 1'b0);
    check("cascade04_d2", if2.seg, if2.rbo, 7'h66, 1'b1);

    // Cascade: digits 0,0 -> both blank.
    @(negedge clk);
    if2.bcd = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("cascade00_d1", if1.seg, if1.rbo, 7'h00, 1'b0);
    check("cascade00_d2", if2.seg, if2.rbo, 7'h00, 1'b0);

    // Cascade: leading digit nonzero stops the ripple, so 5,0 shows "50".
    @(negedge clk);
    if1.bcd = 4'd5;
    repeat (3) @(posedge clk);
    #1;
    check("cascade50_d1", if1.seg, if1.rbo, 7'h6D, 1'b1);
    check("cascade50_d2", if2.seg, if2.rbo, 7'h3F, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
